button_debounce: RTL

// - Conditions the raw push-button inputs (ui_in[3:0]) before they reach the

---
 rtl/button_debounce.sv | 136 +++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// Push-button conditioner: per channel a 2-flop synchroniser, a counter-based
// debounce, and registered press/release/auto-repeat single-cycle pulses.
module button_debounce #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DB_CYCLES     = 50000,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int unsigned DB_MAX  = (DB_CYCLES > 2) ? DB_CYCLES : 2;
  localparam int unsigned RP_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_MAX  = (RP_SPAN > 2) ? RP_SPAN : 2;
  localparam int unsigned DB_W    = $clog2(DB_MAX);
  localparam int unsigned RP_W    = $clog2(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST        = DB_W'((DB_CYCLES > 0) ? DB_CYCLES - 1 : 0);
  localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit              REPEAT_ON      = (REPEAT_DELAY != 0);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  logic [N_BTN-1:0] s1_q;
  logic [N_BTN-1:0] s2_q;

  // Two-flop synchroniser; keeps sampling even while ena is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t          state_q, state_d;
    logic [DB_W-1:0] db_q, db_d;
    logic [RP_W-1:0] rp_q, rp_d;
    logic            rp_periodic_q, rp_periodic_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            repeat_q, repeat_d;

    // Channel state, counters and registered pulse outputs.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q       <= ST_IDLE;
        db_q          <= '0;
        rp_q          <= '0;
        rp_periodic_q <= 1'b0;
        press_q       <= 1'b0;
        release_q     <= 1'b0;
        repeat_q      <= 1'b0;
      end else begin
        state_q       <= state_d;
        db_q          <= db_d;
        rp_q          <= rp_d;
        rp_periodic_q <= rp_periodic_d;
        press_q       <= press_d;
        release_q     <= release_d;
        repeat_q      <= repeat_d;
      end
    end

    // Debounce acceptance, level FSM and auto-repeat scheduling.
    always_comb begin
      state_d       = state_q;
      db_d          = db_q;
      rp_d          = rp_q;
      rp_periodic_d = rp_periodic_q;
      press_d       = 1'b0;
      release_d     = 1'b0;
      repeat_d      = 1'b0;

      if (ena) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!s2_q[i]) begin
              db_d = '0;
            end else if (db_q == DB_LAST) begin
              state_d       = ST_PRESSED;
              db_d          = '0;
              press_d       = 1'b1;
              rp_d          = '0;
              rp_periodic_d = 1'b0;
            end else begin
              db_d = db_q + DB_W'(1);
            end
          end

          ST_PRESSED: begin
            if (!s2_q[i] && (db_q == DB_LAST)) begin
              state_d       = ST_IDLE;
              db_d          = '0;
              release_d     = 1'b1;
              rp_d          = '0;
              rp_periodic_d = 1'b0;
            end else begin
              db_d = s2_q[i] ? '0 : db_q + DB_W'(1);
              // First pulse after the hold delay, then one per period.
              if (REPEAT_ON) begin
                if (rp_q == (rp_periodic_q ? RP_PERIOD_LAST : RP_DELAY_LAST)) begin
                  repeat_d      = 1'b1;
                  rp_d          = '0;
                  rp_periodic_d = 1'b1;
                end else begin
                  rp_d = rp_q + RP_W'(1);
                end
              end
            end
          end
        endcase
      end
    end

    assign btn_level[i]   = (state_q == ST_PRESSED);
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule
